pac_dir_ctrl: RTL and testbench
===============================

# pac_dir_ctrl

Direction source for the Pac-Man position controller. Synchronises and debounces the four direction buttons, buffers the most recent turn request, and on each move tick probes the map for the requested and current headings. It drives the controller's `dir_in` with exactly one single-cycle move command per tick, and `WAIT` otherwise. It sits between the board buttons and `control_pacman`, and shares a map lookup port with it.

## Interface
Parameters:
- `TICK_DIV`, default 1000000: clock cycles per move tick. Minimum 4.
- `DB_CYCLES`, default 50000: consecutive stable samples required to accept a key level. Minimum 1.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: game running; gates tick generation.
- `key_n` in 4: asynchronous active-low buttons. Bit 0 = right, 1 = up, 2 = left, 3 = down.
- `x_in` in 8: current Pac-Man x, tile units (0..26).
- `y_in` in 7: current Pac-Man y, tile units (0..23).
- `probe_x` out 8: x of the neighbour tile being probed (combinational).
- `probe_y` out 7: y of the neighbour tile being probed (combinational).
- `probe_wall` in 1: map result for (`probe_x`, `probe_y`). 1 = wall. Combinational, valid in the same cycle.
- `dir_out` out 3: command to controller. 000 right, 001 up, 010 left, 011 down, 100 WAIT.
- `heading` out 2: last accepted direction, for the sprite shaper.
- `step` out 1: high in the cycle `dir_out` carries a move.

## Operation
- **Input path per key:**
  - 2-flop synchroniser.
  - Debounce counter. The accepted level changes only after `DB_CYCLES` consecutive samples that differ from the current accepted level. Any matching sample clears the counter.
  - A press is the accepted level going released→pressed, as a one-cycle event.
- **Request latch:**
  - A press event loads `req_dir` and sets `req_valid`.
  - Simultaneous presses resolve with priority right > up > left > down.
  - A newer press overwrites a pending request.
- **Tick:**
  - While `enable`=1, the counter counts 0..`TICK_DIV`-1 and emits a one-cycle registered `tick` at the terminal count, then wraps to 0.
  - While `enable`=0, the counter is held at 0 and no tick is emitted.
- **Probe target:** neighbour of (`x_in`, `y_in`) in the selected direction. Selected direction is `req_dir` in CHK_REQ, otherwise `heading`. Tunnel wrap rules:
  - right at x=26 → x=0.
  - left at x=0 → x=26.
  - up at y=0 → y=23.
  - down at y=23 → y=0.
- **FSM:**
  - WAIT: `dir_out`=100.
    - On `tick`: if `req_valid`, go to CHK_REQ.
    - Else if `moving`, go to CHK_CUR.
    - Else stay in WAIT.
  - CHK_REQ:
    - If `probe_wall`=0: `heading`←`req_dir`, `req_valid`←0, `moving`←1, go to MOVE.
    - Else if `moving`, go to CHK_CUR. The request is retained.
    - Else go to WAIT.
  - CHK_CUR:
    - If `probe_wall`=0, go to MOVE.
    - Else `moving`←0, go to WAIT.
  - MOVE: `dir_out`=`heading`, `step`=1 for one cycle, then go to WAIT.
- **`enable` falling mid-sequence:** the in-flight CHK/MOVE sequence completes; no further ticks occur. Requests are still latched while `enable`=0.
- **Press during CHK_REQ:** a press event takes effect after that state. CHK_REQ uses the value latched on entry.

## Timing
- **Reset values:**
  - `dir_out`=100, `step`=0, `heading`=10 (left).
  - `moving`=0, `req_valid`=0.
  - Tick counter=0, debounce counters=0, accepted levels=released, FSM=WAIT.
- **Key latency:** button edge to `req_valid`=1 is 2 + `DB_CYCLES` + 1 cycles.
- **Move latency:**
  - `tick` at cycle T, request accepted: `dir_out` valid at T+2.
  - `tick` at T, request blocked, current heading open: `dir_out` valid at T+3.
- **Command rate:** at most one non-WAIT `dir_out` cycle per tick. `dir_out` is never non-WAIT for two consecutive cycles.
- **Input stability:** `x_in`/`y_in` must be stable from tick through MOVE. The controller updates only on the cycle after a MOVE.

## Configuration
- `PACDIR_REQ_EXPIRE_EN`:
  - Defined: a pending request that has not been accepted within 8 ticks is cleared (`req_valid`←0). A 3-bit age counter is reset on each press and incremented on each tick while `req_valid`.
  - Undefined: requests persist until accepted or overwritten.

## Test plan
All scenarios use `TICK_DIV`=8 and `DB_CYCLES`=4.
- **Reset:** hold `reset_n`=0 for 3 cycles → `dir_out`=100, `step`=0, `heading`=10. No step for 40 cycles with no keys pressed.
- **First move:** hold `key_n`=1110 for 10 cycles, `probe_wall`=0 → 000 is issued for one cycle 2 cycles after the next tick and repeats every 8 cycles. `heading`=00.
- **Buffered turn:** while moving right, press up with `probe_wall`=1 only for up probes → 000 continues each tick. Clear the up wall → next command is 001 and `heading`=01.
- **Wall stop:** moving right, `probe_wall`=1 on the right probe → no step, `dir_out` stays 100, subsequent ticks issue nothing.
- **Wrap probe:** `x_in`=26, `heading`=right in CHK_CUR → `probe_x`=0, `probe_y`=`y_in`. `x_in`=0 left → `probe_x`=26. `y_in`=0 up → `probe_y`=23.
- **Debounce and expiry:**
  - A 2-cycle glitch on `key_n[1]` → no request.
  - With `PACDIR_REQ_EXPIRE_EN`, a blocked request clears after 8 ticks. Without the macro it is still pending at 20 ticks.

Source files
------------

// File: rtl/pac_dir_ctrl_if.sv
// pac_dir_ctrl_if: map probe and move-command bundle; master = direction source (drives probe_x/probe_y/dir_out/heading/step), slave = controller/map side (drives x_in/y_in/probe_wall)
interface pac_dir_ctrl_if;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [7:0] probe_x;
  logic [6:0] probe_y;
  logic       probe_wall;
  logic [2:0] dir_out;
  logic [1:0] heading;
  logic       step;
  modport master (input x_in, y_in, probe_wall, output probe_x, probe_y, dir_out, heading, step);
  modport slave (output x_in, y_in, probe_wall, input probe_x, probe_y, dir_out, heading, step);
endinterface

// File: rtl/pac_dir_ctrl.sv
// pac_dir_ctrl: debounced buttons to one move command per tick; ports clock, reset_n (sync active-low), enable, key_n[3:0], bus (pac_dir_ctrl_if.master); define PACDIR_REQ_EXPIRE_EN to drop requests unaccepted after 8 ticks
module pac_dir_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] key_n,
  pac_dir_ctrl_if.master bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {S_WAIT, S_CHK_REQ, S_CHK_CUR, S_MOVE} state_t;
  state_t state, state_d;
  logic [3:0] sync1, sync2, acc, acc_q, press;
  logic [DW-1:0] db_cnt [4];
  logic [TW-1:0] tick_cnt;
  logic tick, req_valid, moving, expire;
  logic [1:0] req_dir, head, press_dir, sel;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= 4'hf;
      sync2 <= 4'hf;
      acc   <= 4'h0;
      acc_q <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      acc_q <= acc;
      for (int i = 0; i < 4; i++) begin
        if (~sync2[i] == acc[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          acc[i]    <= ~sync2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end
  assign press = acc & ~acc_q;
  assign press_dir = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= tick_cnt == TW'(TICK_DIV - 1);
      tick_cnt <= tick_cnt == TW'(TICK_DIV - 1) ? '0 : tick_cnt + 1'b1;
    end
  end
`ifdef PACDIR_REQ_EXPIRE_EN
  logic [2:0] age;
  always_ff @(posedge clock) begin
    if (!reset_n || |press) age <= 3'd0;
    else if (tick && req_valid) age <= age + 3'd1;
  end
  assign expire = tick & req_valid & (age == 3'd7);
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_dir   <= 2'd0;
      req_valid <= 1'b0;
      head      <= 2'd2;
      moving    <= 1'b0;
    end else begin
      if (|press) begin
        req_dir   <= press_dir;
        req_valid <= 1'b1;
      end else if ((state == S_CHK_REQ && !bus.probe_wall) || expire) req_valid <= 1'b0;
      if (state == S_CHK_REQ && !bus.probe_wall) begin
        head   <= req_dir;
        moving <= 1'b1;
      end else if (state == S_CHK_CUR && bus.probe_wall) moving <= 1'b0;
    end
  end
  always_ff @(posedge clock) state <= !reset_n ? S_WAIT : state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_WAIT:    state_d = !tick ? S_WAIT : (req_valid && !expire) ? S_CHK_REQ : moving ? S_CHK_CUR : S_WAIT;
      S_CHK_REQ: state_d = !bus.probe_wall ? S_MOVE : moving ? S_CHK_CUR : S_WAIT;
      S_CHK_CUR: state_d = !bus.probe_wall ? S_MOVE : S_WAIT;
      default:   state_d = S_WAIT;
    endcase
    bus.step    = state == S_MOVE;
    bus.dir_out = state == S_MOVE ? {1'b0, head} : 3'b100;
  end
  assign bus.heading = head;
  assign sel = state == S_CHK_REQ ? req_dir : head;
  always_comb begin
    bus.probe_x = sel == 2'd0 ? (bus.x_in == 8'd26 ? 8'd0 : bus.x_in + 8'd1)
                : sel == 2'd2 ? (bus.x_in == 8'd0 ? 8'd26 : bus.x_in - 8'd1) : bus.x_in;
    bus.probe_y = sel == 2'd1 ? (bus.y_in == 7'd0 ? 7'd23 : bus.y_in - 7'd1)
                : sel == 2'd3 ? (bus.y_in == 7'd23 ? 7'd0 : bus.y_in + 7'd1) : bus.y_in;
  end
endmodule

// File: tb/tb_pac_dir_ctrl.sv
// tb_pac_dir_ctrl: randomized scoreboard bench for pac_dir_ctrl against a tick-level reference model
module tb_pac_dir_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] key_n = 4'hf;
  pac_dir_ctrl_if bus();
  pac_dir_ctrl #(.TICK_DIV(8), .DB_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .key_n(key_n), .bus(bus.master)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  logic walls [27][24];
  always_comb bus.probe_wall = (bus.probe_x < 8'd27 && bus.probe_y < 7'd24) ? walls[int'(bus.probe_x)][int'(bus.probe_y)] : 1'b1;
  typedef struct {int dir; int cyc;} exp_t;
  exp_t exp_q[$];
  int chk_cnt = 0, pass_cnt = 0, steps = 0, pushed = 0;
  int m_head = 2, m_rd = 0, m_age = 0, px = 13, py = 10;
  bit m_mov = 0, m_rv = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void nb(input int d, input int x, input int y, output int nx, output int ny);
    nx = x;
    ny = y;
    case (d)
      0: nx = (x + 1) % 27;
      1: ny = (y + 23) % 24;
      2: nx = (x + 26) % 27;
      default: ny = (y + 1) % 24;
    endcase
  endfunction

  task automatic push(input int d, input int c);
    exp_t e;
    e.dir = d;
    e.cyc = c;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.step) begin
        steps++;
        if (exp_q.size() == 0) chk("unexpected_step", int'(bus.dir_out), 4);
        else begin
          e = exp_q.pop_front();
          chk("step_dir", int'(bus.dir_out), e.dir);
          chk("step_cycle", cyc, e.cyc);
          chk("step_heading", int'(bus.heading), e.dir);
        end
      end else chk("idle_dir", int'(bus.dir_out), 4);
    end
  endtask

  task automatic set_pos(input int x, input int y);
    @(negedge clock);
    px = x;
    py = y;
    bus.x_in = 8'(x);
    bus.y_in = 7'(y);
  endtask

  task automatic fill_walls(input int pct);
    for (int i = 0; i < 27; i++)
      for (int j = 0; j < 24; j++) walls[i][j] = $urandom_range(0, 99) < pct;
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clock);
    key_n = ~mask;
    repeat (8) @(negedge clock);
    key_n = 4'hf;
    repeat (8) @(negedge clock);
    m_rv = 1;
    m_age = 0;
    m_rd = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
  endtask

  task automatic glitch(input int b);
    @(negedge clock);
    key_n[b] = 1'b0;
    repeat (2) @(negedge clock);
    key_n[b] = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic check_idle();
    int nx, ny;
    @(negedge clock);
    nb(m_head, px, py, nx, ny);
    chk("heading", int'(bus.heading), m_head);
    chk("probe_x", int'(bus.probe_x), nx);
    chk("probe_y", int'(bus.probe_y), ny);
  endtask

  task automatic run_tick();
    int k, nx, ny;
    bit done, blocked;
    @(negedge clock);
    enable = 1'b1;
    repeat (8) @(posedge clock);
    #1 enable = 1'b0;
    k = cyc;
    done = 0;
    blocked = 0;
`ifdef PACDIR_REQ_EXPIRE_EN
    if (m_rv) begin
      if (m_age == 7) m_rv = 0;
      else m_age++;
    end
`endif
    if (m_rv) begin
      nb(m_rd, px, py, nx, ny);
      if (!walls[nx][ny]) begin
        m_head = m_rd;
        m_rv = 0;
        m_mov = 1;
        push(m_rd, k + 2);
        done = 1;
      end else blocked = 1;
    end
    if (!done && m_mov) begin
      nb(m_head, px, py, nx, ny);
      if (!walls[nx][ny]) push(m_head, blocked ? k + 3 : k + 2);
      else m_mov = 0;
    end
    repeat (12) @(negedge clock);
    chk("missing_step", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int act;
    fill_walls(0);
    bus.x_in = 8'(px);
    bus.y_in = 7'(py);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_dir", int'(bus.dir_out), 4);
    chk("reset_step", int'(bus.step), 0);
    chk("reset_heading", int'(bus.heading), 2);
    reset_n = 1'b1;
    fork
      monitor();
    join_none
    enable = 1'b1;
    repeat (40) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      fill_walls(0);
      case (d)
        0: set_pos(26, 5);
        1: set_pos(4, 0);
        2: set_pos(0, 7);
        default: set_pos(9, 23);
      endcase
      press(4'(1 << d));
      run_tick();
      check_idle();
    end
    for (int r = 0; r < 80; r++) begin
      fill_walls(30);
      set_pos($urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 26 : 0) : $urandom_range(0, 26),
              $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 23 : 0) : $urandom_range(0, 23));
      act = $urandom_range(0, 5);
      if (act >= 1 && act <= 3) press(4'($urandom_range(1, 15)));
      else if (act == 4) begin
        press(4'($urandom_range(1, 15)));
        press(4'($urandom_range(1, 15)));
      end else if (act == 5) glitch($urandom_range(0, 3));
      check_idle();
      run_tick();
      check_idle();
    end
    fill_walls(100);
    set_pos(10, 10);
    run_tick();
    run_tick();
    press(4'b0010);
    repeat (20) run_tick();
    fill_walls(0);
    run_tick();
    check_idle();
    chk("step_count", steps, pushed);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
